sdram_clk_sequencer: RTL

Power-up and recovery sequencer for the SDRAM clock PLL. It drives the PLL reset and qualifies the raw PLL lock. It enforces the SDRAM power-up stabilisation delay, then hands off to the SDRAM controller's init sequence. It runs on the board reference clock, the same clock that feeds the PLL, so it keeps operating while the PLL is unlocked. It retries on lock timeout and restarts the whole sequence on lock loss.

---
 rtl/sdram_clk_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sdram_clk_sequencer.sv
// sdram_clk_sequencer
// Power-up and recovery sequencer for the SDRAM clock PLL. Runs on the board
// reference clock (the PLL input), so it keeps running while the PLL is
// unlocked. It pulses the PLL reset, filters the raw lock, waits out the SDRAM
// stabilisation delay, then starts the SDRAM controller init. A lock timeout
// triggers a retry; a lock loss after acceptance restarts the sequence.
//
// Ports
//   clk          reference clock (same net as PLL CLKIN)
//   rst          asynchronous reset, active low
//   pll_locked   raw PLL lock, asynchronous to clk
//   restart      one-cycle request to rerun the full sequence
//   init_done    SDRAM controller init complete (level)
//   pll_rst      PLL reset, active high
//   clk_stable   lock accepted and held
//   init_start   one-cycle pulse starting SDRAM init
//   sdram_en     SDRAM path may run
//   fault        PLL reset retries exhausted
//   lock_lost    one-cycle pulse when lock drops after acceptance
//   retry_count  PLL reset retries used
//   state        current state encoding (debug)
//
// state     | meaning
// ----------+-------------------------------------------------
// RESET_PLL | pll_rst held high for RST_CYCLES
// WAIT_LOCK | waiting for synced lock, bounded by LOCK_TIMEOUT
// FILTER    | lock must stay high LOCK_FILTER cycles in a row
// POWERUP   | SDRAM stabilisation delay, clock accepted
// INIT      | SDRAM controller init running
// RUN       | normal operation
// FAULT     | retries exhausted; PLL kept in reset until restart

module sdram_clk_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LOCK_FILTER    = 64,
  parameter int unsigned POWERUP_CYCLES = 10000,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  input  logic       init_done,
  output logic       pll_rst,
  output logic       clk_stable,
  output logic       init_start,
  output logic       sdram_en,
  output logic       fault,
  output logic       lock_lost,
  output logic [1:0] retry_count,
  output logic [2:0] state
);

  localparam logic [2:0] RESET_PLL = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] FILTER    = 3'd2;
  localparam logic [2:0] POWERUP   = 3'd3;
  localparam logic [2:0] INIT      = 3'd4;
  localparam logic [2:0] RUN       = 3'd5;
  localparam logic [2:0] FAULT     = 3'd6;

  localparam logic [23:0] RST_LAST = 24'(RST_CYCLES - 1);
  localparam logic [23:0] TO_LAST  = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] PU_LAST  = 24'(POWERUP_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock counts as the first filter
  // cycle, so FILTER itself only needs LOCK_FILTER-1 more high cycles.
  localparam logic [23:0] FILT_LAST = 24'((LOCK_FILTER > 1) ? (LOCK_FILTER - 2) : 0);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRIES);
  localparam bit          FILT_SKIP = (LOCK_FILTER <= 1);

  logic        sync1;
  logic        locked_s;
  logic [23:0] cnt;
  logic [2:0]  state_nxt;
  logic [1:0]  retry_nxt;
  logic        lost_nxt;
  logic        lock_drop;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    lost_nxt  = 1'b0;
    lock_drop = !locked_s && (state == POWERUP || state == INIT || state == RUN);
    // restart outranks lock loss, which outranks the normal transitions
    if (restart && state != RESET_PLL) begin
      state_nxt = RESET_PLL;
      retry_nxt = 2'd0;
    end else if (lock_drop) begin
      state_nxt = RESET_PLL;
      lost_nxt  = 1'b1;
    end else begin
      case (state)
        RESET_PLL: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = FILT_SKIP ? POWERUP : FILTER;
          end else if (cnt == TO_LAST) begin
            if (retry_count < RETRY_MAX) begin
              retry_nxt = retry_count + 2'd1;
              state_nxt = RESET_PLL;
            end else begin
              state_nxt = FAULT;
            end
          end
        end
        FILTER: begin
          if (!locked_s)              state_nxt = WAIT_LOCK;
          else if (cnt == FILT_LAST)  state_nxt = POWERUP;
        end
        POWERUP: if (cnt == PU_LAST) state_nxt = INIT;
        INIT: begin
          if (init_done) begin
            state_nxt = RUN;
            retry_nxt = 2'd0;
          end
        end
        RUN, FAULT: ;
        default: state_nxt = RESET_PLL;
      endcase
    end
  end

  // Outputs are registered from the next state so they change together with
  // the state register and never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= 1'b0;
      locked_s    <= 1'b0;
      state       <= RESET_PLL;
      cnt         <= 24'd0;
      retry_count <= 2'd0;
      pll_rst     <= 1'b1;
      clk_stable  <= 1'b0;
      sdram_en    <= 1'b0;
      fault       <= 1'b0;
      init_start  <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      sync1       <= pll_locked;
      locked_s    <= sync1;
      state       <= state_nxt;
      cnt         <= (state_nxt != state) ? 24'd0 : cnt + 24'd1;
      retry_count <= retry_nxt;
      pll_rst     <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      clk_stable  <= (state_nxt == POWERUP) || (state_nxt == INIT) || (state_nxt == RUN);
      sdram_en    <= (state_nxt == RUN);
      fault       <= (state_nxt == FAULT);
      init_start  <= (state == POWERUP) && (state_nxt == INIT);
      lock_lost   <= lost_nxt;
    end
  end

endmodule
